// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the 4-bit data bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a; requesters hold req level until they are done with the bus.
package bus_arb_pkg;

    // Default requester count; requester index doubles as its owner id.
    localparam int N_REQ_DEF = 4;

    // Bus requester ids as wired to the busDriver enables.
    localparam int REQ_OPRND = 0;
    localparam int REQ_ALU   = 1;
    localparam int REQ_IN    = 2;
    localparam int REQ_RAM   = 3;

    // IDLE: no owner; GRANT: one owner drives; TURN: forced dead cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// Latency: n/a (wires only).
// Backpressure: level req held by a requester until it releases the bus.
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  owner;
    logic             owner_valid;
    logic             bus_idle;
    logic             wd_timeout;

    // Arbiter side: samples requests, drives grants and status.
    modport master (
        input  req,
        output gnt,
        output owner,
        output owner_valid,
        output bus_idle,
        output wd_timeout
    );

    // Requester side: raises requests, observes grants.
    modport slave (
        output req,
        input  gnt,
        input  owner,
        input  owner_valid,
        input  bus_idle,
        input  wd_timeout
    );
endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit scanning from ptr upward, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [ID_W-1:0]  o_id,
    output logic             o_any
);

    // Walk the requesters starting at ptr and keep the first one found.
    always_comb begin
        int w_idx;
        o_onehot = '0;
        o_id     = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (!o_any && i_req[w_idx]) begin
                o_any           = 1'b1;
                o_id            = ID_W'(w_idx);
                o_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner sequencer for the shared tri-state bus, one dead cycle between owners.
// Latency: grant registered 1 cycle after req is sampled; release 1 cycle after req drops.
// Backpressure: owner keeps the bus while its req is high; BUS_WATCHDOG_EN adds a forced release.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = $clog2(N_REQ),
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic          clk,
    input  logic          Rst_n,
    bus_arbiter_if.master bus
);

    // A hold counter of HOLD_W bits must be able to reach MAX_HOLD-1.
    if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W)) begin : g_bad_hold
        $error("bus_arbiter: MAX_HOLD does not fit in HOLD_W bits");
    end

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  w_owner_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic             r_owner_valid;
    logic             r_bus_idle;
    logic             w_grant_evt;
    logic             w_wd_nxt;

    logic [N_REQ-1:0] w_pick_onehot;
    logic [ID_W-1:0]  w_pick_id;
    logic             w_pick_any;
    logic [ID_W-1:0]  w_pick_id_inc;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_id     (w_pick_id),
        .o_any    (w_pick_any)
    );

    // Pointer lands just past the winner so the winner drops to lowest priority.
    assign w_pick_id_inc = (w_pick_id == ID_W'(N_REQ - 1)) ? '0 : w_pick_id + 1'b1;

`ifdef BUS_WATCHDOG_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_wd_timeout;
    logic              w_hold_expired;

    assign w_hold_expired = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // Hold counter: cleared on every new grant, counts cycles spent in GRANT.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_grant_evt) begin
            r_hold_cnt <= '0;
        end else if (r_state == GRANT) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Timeout flag is high only during the TURN cycle caused by a forced release.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wd_timeout <= 1'b0;
        end else begin
            r_wd_timeout <= w_wd_nxt;
        end
    end

    assign bus.wd_timeout = r_wd_timeout;
`else
    assign bus.wd_timeout = 1'b0;
`endif

    // Next state, next grant vector, pointer update and watchdog release decision.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_grant_evt = 1'b0;
        w_wd_nxt    = 1'b0;
        case (r_state)
            // TURN arbitrates exactly like IDLE, which keeps the gap at one cycle.
            IDLE, TURN: begin
                if (w_pick_any) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_onehot;
                    w_owner_nxt = w_pick_id;
                    w_ptr_nxt   = w_pick_id_inc;
                    w_grant_evt = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                end
            end
            // Only the owner's request matters; others wait for the next TURN.
            GRANT: begin
                if (!bus.req[r_owner]) begin
                    w_state_nxt = TURN;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                end
`ifdef BUS_WATCHDOG_EN
                else if (w_hold_expired) begin
                    w_state_nxt = TURN;
                    w_gnt_nxt   = '0;
                    w_owner_nxt = '0;
                    w_wd_nxt    = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_owner_nxt = '0;
            end
        endcase
    end

    // State, grant and status registers all update together so status never lags gnt.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_owner_valid <= 1'b0;
            r_bus_idle    <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_owner       <= w_owner_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner_valid <= |w_gnt_nxt;
            r_bus_idle    <= ~|w_gnt_nxt;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.owner       = r_owner;
    assign bus.owner_valid = r_owner_valid;
    assign bus.bus_idle    = r_bus_idle;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed req vectors push expected grants,
// a negedge monitor pops and compares, and checks onehot0 plus the owner gap.
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    logic clk   = 1'b0;
    logic Rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.N_REQ(4), .ID_W(2)) bif ();

`ifdef BUS_WATCHDOG_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 15;
`endif

    bus_arbiter #(
        .N_REQ    (4),
        .ID_W     (2),
        .MAX_HOLD (HOLD),
        .HOLD_W   (4)
    ) dut (
        .clk   (clk),
        .Rst_n (Rst_n),
        .bus   (bif.master)
    );

    typedef struct {
        int         tgt;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       wd;
        string      name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic [3:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [1:0] enc(logic [3:0] g);
        logic [1:0] id;
        id = '0;
        for (int i = 0; i < 4; i++) if (g[i]) id = 2'(i);
        return id;
    endfunction

    // Monitor: invariants every cycle, scoreboard entries due this cycle.
    always @(negedge clk) begin
        exp_t e;
        chk("onehot0", 32'($onehot0(bif.gnt)), 32'd1);
        if (prev_gnt != 4'b0 && bif.gnt != 4'b0)
            chk("gap", 32'(bif.gnt), 32'(prev_gnt));
        prev_gnt = bif.gnt;
        while (q.size() > 0 && q[0].tgt <= cyc) begin
            e = q.pop_front();
            if (e.tgt < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: stale entry due %0d seen %0d", e.name, e.tgt, cyc);
            end else begin
                chk({e.name, " gnt"},   32'(bif.gnt),         32'(e.gnt));
                chk({e.name, " owner"}, 32'(bif.owner),       32'(e.owner));
                chk({e.name, " ovld"},  32'(bif.owner_valid), 32'(|e.gnt));
                chk({e.name, " idle"},  32'(bif.bus_idle),    32'(~|e.gnt));
                chk({e.name, " wd"},    32'(bif.wd_timeout),  32'(e.wd));
            end
        end
    end

    // Drive req for the coming edge and queue the outputs expected after it.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic ew, input string nm);
        exp_t e;
        bif.req = r;
        e.tgt   = cyc + 1;
        e.gnt   = eg;
        e.owner = enc(eg);
        e.wd    = ew;
        e.name  = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Async reset mid-cycle, checked before any clock edge, released between edges.
    task automatic do_reset(input string nm);
        @(negedge clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk({nm, " rst gnt"},   32'(bif.gnt),         32'd0);
        chk({nm, " rst owner"}, 32'(bif.owner),       32'd0);
        chk({nm, " rst ovld"},  32'(bif.owner_valid), 32'd0);
        chk({nm, " rst idle"},  32'(bif.bus_idle),    32'd1);
        chk({nm, " rst wd"},    32'(bif.wd_timeout),  32'd0);
        bif.req = '0;
        @(posedge clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        bif.req = '0;
        do_reset("init");

        // Single requester grant and release through one TURN cycle.
        step(4'b0010, 4'b0010, 1'b0, "t2 grant");
        step(4'b0010, 4'b0010, 1'b0, "t2 hold");
        step(4'b0000, 4'b0000, 1'b0, "t2 turn");
        step(4'b0000, 4'b0000, 1'b0, "t2 idle");

        // Grant 2, then assert reset while gnt=0100.
        step(4'b0100, 4'b0100, 1'b0, "t1 grant");
        step(4'b0100, 4'b0100, 1'b0, "t1 hold");
        do_reset("t1");

        // Round robin 0,1,2,3,0 with one dead cycle between owners.
        step(4'b1111, 4'b0001, 1'b0, "t3 g0");
        step(4'b1111, 4'b0001, 1'b0, "t3 g0b");
        step(4'b1110, 4'b0000, 1'b0, "t3 gap0");
        step(4'b1111, 4'b0010, 1'b0, "t3 g1");
        step(4'b1111, 4'b0010, 1'b0, "t3 g1b");
        step(4'b1101, 4'b0000, 1'b0, "t3 gap1");
        step(4'b1111, 4'b0100, 1'b0, "t3 g2");
        step(4'b1111, 4'b0100, 1'b0, "t3 g2b");
        step(4'b1011, 4'b0000, 1'b0, "t3 gap2");
        step(4'b1111, 4'b1000, 1'b0, "t3 g3");
        step(4'b1111, 4'b1000, 1'b0, "t3 g3b");
        step(4'b0111, 4'b0000, 1'b0, "t3 gap3");
        step(4'b1111, 4'b0001, 1'b0, "t3 g0 again");
        step(4'b0000, 4'b0000, 1'b0, "t3 end");
        step(4'b0000, 4'b0000, 1'b0, "t3 idle");

        // Owner release coinciding with a new request.
        do_reset("t4");
        step(4'b0001, 4'b0001, 1'b0, "t4 g0");
        step(4'b0001, 4'b0001, 1'b0, "t4 g0b");
        step(4'b0100, 4'b0000, 1'b0, "t4 turn");
        step(4'b0100, 4'b0100, 1'b0, "t4 g2");
        step(4'b0000, 4'b0000, 1'b0, "t4 end");

        // Owner drops and re-asserts at once: loses to the rotated pointer.
        do_reset("rot");
        step(4'b0011, 4'b0001, 1'b0, "rot g0");
        step(4'b0010, 4'b0000, 1'b0, "rot turn0");
        step(4'b0011, 4'b0010, 1'b0, "rot g1");
        step(4'b0001, 4'b0000, 1'b0, "rot turn1");
        step(4'b0001, 4'b0001, 1'b0, "rot g0 again");
        step(4'b0000, 4'b0000, 1'b0, "rot end");

        // Long hold: watchdog release or indefinite hold depending on build.
        do_reset("t5");
`ifdef BUS_WATCHDOG_EN
        for (int i = 0; i < 4; i++) step(4'b0011, 4'b0001, 1'b0, "t5 hold0");
        step(4'b0011, 4'b0000, 1'b1, "t5 wd0");
        for (int i = 0; i < 4; i++) step(4'b0011, 4'b0010, 1'b0, "t5 hold1");
        step(4'b0011, 4'b0000, 1'b1, "t5 wd1");
        step(4'b0011, 4'b0001, 1'b0, "t5 regrant0");
`else
        for (int i = 0; i < 100; i++) step(4'b0011, 4'b0001, 1'b0, "t5 hold");
`endif
        step(4'b0000, 4'b0000, 1'b0, "t5 end");
        step(4'b0000, 4'b0000, 1'b0, "t5 idle");

        // Random request streams: only the invariants in the monitor apply.
        for (int i = 0; i < 1500; i++) begin
            bif.req = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        bif.req = '0;
        repeat (4) @(posedge clk);
        #1;

        // Directed tail after random traffic settles.
        do_reset("tail");
        step(4'b1000, 4'b1000, 1'b0, "tail g3");
        step(4'b0000, 4'b0000, 1'b0, "tail end");
        repeat (2) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries never checked", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
